return_stack: RTL and testbench
===============================

RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of return-address entries (power of two, 2..64).
REQ-002 The block SHALL have parameter AW, default 19, meaning the address width in bits.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the reset, asynchronous and active-low.
REQ-005 The block SHALL have port call_en  input  1  meaning push request from the control unit for the current CALL instruction.
REQ-006 The block SHALL have port ret_en  input  1  meaning pop request from the control unit for the current RET instruction.
REQ-007 The block SHALL have port push_addr  input  AW  meaning the return address to save (PC+4 of the CALL).
REQ-008 The block SHALL have port err_clr  input  1  meaning synchronous clear of the sticky error flags.
REQ-009 The block SHALL have port stk_ret_inst  output  AW  meaning the current top-of-stack return address, consumed by the next-PC logic.
REQ-010 The block SHALL have port empty  output  1  meaning the stack holds zero entries.
REQ-011 The block SHALL have port full  output  1  meaning the stack holds DEPTH entries.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH)+1  meaning the current number of valid entries.
REQ-013 The block SHALL have port overflow  output  1  meaning sticky flag: a push was attempted while full.
REQ-014 The block SHALL have port underflow  output  1  meaning sticky flag: a pop was attempted while empty.

Function
REQ-015 Storage SHALL be DEPTH x AW registers indexed by a stack pointer sp equal to count; the top entry is mem[sp-1].
REQ-016 stk_ret_inst SHALL be combinational: mem[sp-1] when count>0, else all zeros; it SHALL be valid in the same cycle that ret_en is asserted (zero-latency read).
REQ-017 Push only (call_en=1, ret_en=0, not full): write push_addr to mem[sp], count increments by 1 at the clock edge.
REQ-018 Pop only (ret_en=1, call_en=0, not empty): count decrements by 1 at the clock edge; entry contents are not cleared.
REQ-019 Simultaneous call_en and ret_en with count>0: overwrite mem[sp-1] with push_addr, count unchanged.
REQ-020 Simultaneous call_en and ret_en with count=0: push push_addr (count becomes 1), set underflow.
REQ-021 Push while full (ret_en=0): push ignored, memory and count unchanged, overflow set.
REQ-022 Pop while empty (call_en=0): count stays 0, underflow set, stk_ret_inst remains zero.
REQ-023 overflow and underflow SHALL remain set until err_clr or reset; err_clr takes effect at the next edge, and a new error event in the same cycle as err_clr SHALL win (flag stays 1).
REQ-024 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH), both derived combinationally from count.
REQ-025 count SHALL never exceed DEPTH nor wrap below 0; no circular overwrite of the oldest entry is permitted.
REQ-026 With call_en=ret_en=0 the stack state SHALL hold.

Reset
REQ-027 While rst=0, count SHALL be 0, overflow and underflow 0, hence empty=1, full=0, stk_ret_inst=0, regardless of clk.
REQ-028 Memory contents SHALL not require reset; no output may expose unreset memory while empty.
REQ-029 Reset asserted mid-operation SHALL abandon any push/pop in progress; after release the first edge with call_en=1 writes mem[0].

Verification
REQ-030 Reset then call_en with push_addr=19'h00010 -> count=1, stk_ret_inst=19'h00010, empty=0.
REQ-031 Push 19'h00010, 19'h00020, 19'h00030, then three ret_en cycles -> stk_ret_inst shows 19'h00030, 19'h00020, 19'h00010 in the pop cycles; then empty=1, stk_ret_inst=0.
REQ-032 DEPTH=8: nine consecutive pushes of 1..9 -> full=1 after 8th, overflow=1 after 9th, top remains 8, count=8.
REQ-033 Empty stack, ret_en=1 -> underflow=1, count=0; then err_clr=1 one cycle -> underflow=0.
REQ-034 count=2 top=19'h00100, call_en=ret_en=1 with push_addr=19'h00200 -> count=2, stk_ret_inst=19'h00200, entry below unchanged.
REQ-035 count=3, assert rst=0 asynchronously between edges -> count, empty, full, flags take reset values immediately, stk_ret_inst=0.

Source files
------------

// File: rtl/return_stack.sv
// Return-address stack for CALL/RET prediction: DEPTH x AW register file with
// a saturating pointer, zero-latency top-of-stack read and sticky error flags.
module return_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       call_en,
    input  logic                       ret_en,
    input  logic [AW-1:0]              push_addr,
    input  logic                       err_clr,
    output logic [AW-1:0]              stk_ret_inst,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] count_nxt;
    logic          overflow_nxt;
    logic          underflow_nxt;
    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] top_idx;

    assign top_idx = PW'(count - CW'(1));

    // Status and top-of-stack are derived from the pointer without a register stage
    always_comb begin
        empty        = (count == '0);
        full         = (count == CW'(DEPTH));
        stk_ret_inst = empty ? '0 : mem[top_idx];
    end

    // Next pointer, write strobe and sticky-flag update; error events beat err_clr
    always_comb begin
        count_nxt     = count;
        overflow_nxt  = overflow & ~err_clr;
        underflow_nxt = underflow & ~err_clr;
        wr_en         = 1'b0;
        wr_idx        = count[PW-1:0];
        unique case ({call_en, ret_en})
            2'b10: begin
                if (full) begin
                    overflow_nxt = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    count_nxt = count + CW'(1);
                end
            end
            2'b01: begin
                if (empty) begin
                    underflow_nxt = 1'b1;
                end else begin
                    count_nxt = count - CW'(1);
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    wr_idx        = '0;
                    count_nxt     = CW'(1);
                    underflow_nxt = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Entry storage is never reset; empty masks stale contents on the read port
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            mem[wr_idx] <= push_addr;
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// Scoreboard bench for return_stack: a queue-based reference model predicts the
// visible state each cycle; a negedge monitor pops and compares.
module tb_return_stack;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 19;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          call_en = 1'b0;
    logic          ret_en = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic          err_clr = 1'b0;
    logic [AW-1:0] stk_ret_inst;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    return_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .call_en(call_en), .ret_en(ret_en),
        .push_addr(push_addr), .err_clr(err_clr), .stk_ret_inst(stk_ret_inst),
        .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] top;
        logic [CW-1:0] cnt;
        logic          emp;
        logic          ful;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t            expq[$];
    logic [AW-1:0]   model_stk[$];
    logic            model_ovf = 1'b0;
    logic            model_unf = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;
    bit              stim_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Current architecturally visible state of the reference stack
    task automatic push_expect();
        exp_t e;
        e.top = (model_stk.size() > 0) ? model_stk[model_stk.size()-1] : '0;
        e.cnt = CW'(model_stk.size());
        e.emp = (model_stk.size() == 0);
        e.ful = (model_stk.size() == DEPTH);
        e.ovf = model_ovf;
        e.unf = model_unf;
        expq.push_back(e);
    endtask

    task automatic model_edge(input logic c, input logic r, input logic [AW-1:0] a, input logic clr);
        logic o, u;
        o = model_ovf & ~clr;
        u = model_unf & ~clr;
        if (c && !r) begin
            if (model_stk.size() == DEPTH) o = 1'b1;
            else model_stk.push_back(a);
        end else if (r && !c) begin
            if (model_stk.size() == 0) u = 1'b1;
            else void'(model_stk.pop_back());
        end else if (c && r) begin
            if (model_stk.size() == 0) begin
                model_stk.push_back(a);
                u = 1'b1;
            end else begin
                model_stk[model_stk.size()-1] = a;
            end
        end
        model_ovf = o;
        model_unf = u;
    endtask

    // Called at posedge+1: drive, record expectation, advance one edge
    task automatic step(input logic c, input logic r, input logic [AW-1:0] a, input logic clr);
        call_en = c; ret_en = r; push_addr = a; err_clr = clr;
        push_expect();
        @(posedge clk);
        model_edge(c, r, a, clr);
        #1;
    endtask

    // Asynchronous reset asserted between edges, held for one full cycle
    task automatic do_reset();
        call_en = 1'b0; ret_en = 1'b0; err_clr = 1'b0;
        #2;
        rst = 1'b0;
        model_stk.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        push_expect();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("top",       32'(stk_ret_inst), 32'(e.top));
                check("count",     32'(count),        32'(e.cnt));
                check("empty",     32'(empty),        32'(e.emp));
                check("full",      32'(full),         32'(e.ful));
                check("overflow",  32'(overflow),     32'(e.ovf));
                check("underflow", 32'(underflow),    32'(e.unf));
            end
        end
    end

    initial begin : stimulus
        int r;
        @(posedge clk);
        #1;
        push_expect();
        @(posedge clk);
        #1;
        rst = 1'b1;

        step(1, 0, 19'h00010, 0);
        step(0, 0, 19'h0, 0);
        do_reset();
        step(1, 0, 19'h00010, 0);
        step(1, 0, 19'h00020, 0);
        step(1, 0, 19'h00030, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 19'h0, 0);
        step(0, 0, 19'h0, 0);

        for (int i = 1; i <= 9; i++) step(1, 0, AW'(i), 0);
        step(0, 0, 19'h0, 0);
        step(1, 0, 19'h7ffff, 1);
        step(0, 0, 19'h0, 1);
        for (int i = 0; i < 9; i++) step(0, 1, 19'h0, 0);
        step(0, 0, 19'h0, 1);
        step(0, 0, 19'h0, 0);

        step(1, 1, 19'h00055, 0);
        step(0, 0, 19'h0, 1);
        step(0, 1, 19'h0, 0);

        step(1, 0, 19'h00080, 0);
        step(1, 0, 19'h00100, 0);
        step(1, 1, 19'h00200, 0);
        step(0, 1, 19'h0, 0);
        step(0, 1, 19'h0, 0);

        step(1, 0, 19'h00011, 0);
        step(1, 0, 19'h00022, 0);
        step(1, 0, 19'h00033, 0);
        do_reset();
        step(1, 0, 19'h00444, 0);
        step(0, 1, 19'h0, 0);

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(99));
            if (r < 1) begin
                do_reset();
            end else begin
                step(logic'($urandom_range(99) < 50),
                     logic'($urandom_range(99) < 42),
                     AW'($urandom),
                     logic'($urandom_range(99) < 6));
            end
        end
        step(0, 0, 19'h0, 0);
        stim_done = 1'b1;
    end

    initial begin : finisher
        wait (stim_done);
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
